// File: rtl/lna_pwr_seq_if.sv
// CPU register-bus bundle for the LNA power sequencer.
// The master drives requests; the slave returns a one-cycle ready with read data.
interface lna_pwr_seq_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic [1:0]        address;
    logic [DATA_W-1:0] wdata;
    logic              wstrb;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output valid, address, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, address, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/lna_pwr_seq.sv
// Receive-LNA power/mode sequencer: arbitrates CPU and MAC control of pd/mode
// and holds off rx_rdy until the programmed wake or mode-change settle time has elapsed.
module lna_pwr_seq #(
    parameter int               DATA_W   = 32,
    parameter int               CNT_W    = 16,
    parameter logic [CNT_W-1:0] WAKE_DEF = CNT_W'(200),
    parameter logic [CNT_W-1:0] MODE_DEF = CNT_W'(20)
) (
    input  logic                clk,
    input  logic                rst_n,
    lna_pwr_seq_if.slave        bus,
    input  logic                rx_req,
    input  logic [1:0]          rx_mode,
    output logic                rx_rdy,
    output logic                pd,
    output logic [1:0]          mode
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        MCHG = 2'd3
    } state_t;

    state_t           state;
    logic [2:0]       ctrl;
    logic [CNT_W-1:0] wake_cyc;
    logic [CNT_W-1:0] mode_cyc;
    logic [CNT_W-1:0] cnt;
    logic [DATA_W-1:0] rd_val;

    logic             sw_en;
    logic [1:0]       sw_mode;
    logic             en_t;
    logic [1:0]       mode_t;

    logic             unused_wdata;
    assign unused_wdata = ^bus.wdata[DATA_W-1:CNT_W];

    assign sw_en   = ctrl[0];
    assign sw_mode = ctrl[2:1];

    // MAC request overrides the software mode whenever it is asserted.
    assign en_t    = sw_en | rx_req;
    assign mode_t  = rx_req ? rx_mode : sw_mode;

    always_comb begin
        rd_val = '0;
        case (bus.address)
            2'd0:    rd_val = DATA_W'(ctrl);
            2'd1:    rd_val = DATA_W'(wake_cyc);
            2'd2:    rd_val = DATA_W'(mode_cyc);
            default: rd_val = DATA_W'({(state == ON), 2'(state)});
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ready <= 1'b0;
            bus.rdata <= '0;
            ctrl      <= '0;
            wake_cyc  <= WAKE_DEF;
            mode_cyc  <= MODE_DEF;
        end else begin
            bus.ready <= bus.valid;
            bus.rdata <= (bus.valid && !bus.wstrb) ? rd_val : '0;
            if (bus.valid && bus.wstrb) begin
                case (bus.address)
                    2'd0:    ctrl     <= bus.wdata[2:0];
                    2'd1:    wake_cyc <= bus.wdata[CNT_W-1:0];
                    2'd2:    mode_cyc <= bus.wdata[CNT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Priority within every active state: disable, then mode change, then expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= OFF;
            pd     <= 1'b1;
            mode   <= 2'd0;
            cnt    <= '0;
            rx_rdy <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    rx_rdy <= 1'b0;
                    if (en_t) begin
                        state <= WAKE;
                        pd    <= 1'b0;
                        mode  <= mode_t;
                        cnt   <= wake_cyc;
                    end
                end
                WAKE, MCHG: begin
                    if (!en_t) begin
                        state  <= OFF;
                        pd     <= 1'b1;
                        rx_rdy <= 1'b0;
                    end else if (mode_t != mode) begin
                        mode   <= mode_t;
                        cnt    <= (state == WAKE) ? wake_cyc : mode_cyc;
                        rx_rdy <= 1'b0;
                    end else if (cnt == '0) begin
                        state  <= ON;
                        rx_rdy <= rx_req && (mode == rx_mode);
                    end else begin
                        cnt    <= cnt - CNT_W'(1);
                        rx_rdy <= 1'b0;
                    end
                end
                default: begin
                    if (!en_t) begin
                        state  <= OFF;
                        pd     <= 1'b1;
                        rx_rdy <= 1'b0;
                    end else if (mode_t != mode) begin
                        state  <= MCHG;
                        mode   <= mode_t;
                        cnt    <= mode_cyc;
                        rx_rdy <= 1'b0;
                    end else begin
                        rx_rdy <= rx_req && (mode == rx_mode);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lna_pwr_seq.sv
// Bench for lna_pwr_seq: register table, directed settle/arbitration sequences,
// then random traffic against a timestamp-based reference model.
module tb_lna_pwr_seq;
    localparam int DATA_W = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_req = 1'b0;
    logic [1:0] rx_mode = 2'd0;
    logic       rx_rdy;
    logic       pd;
    logic [1:0] mode;

    lna_pwr_seq_if #(.DATA_W(DATA_W)) bus ();

    lna_pwr_seq #(
        .DATA_W   (DATA_W),
        .CNT_W    (16),
        .WAKE_DEF (16'd200),
        .MODE_DEF (16'd20)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .rx_req  (rx_req),
        .rx_mode (rx_mode),
        .rx_rdy  (rx_rdy),
        .pd      (pd),
        .mode    (mode)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic cpu_access(input logic [1:0] a, input logic w, input logic [31:0] d,
                              output logic [31:0] rd, output logic rdy);
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.address = a;
        bus.wstrb   = w;
        bus.wdata   = d;
        @(posedge clk);
        #1;
        rd = bus.rdata;
        rdy = bus.ready;
        bus.valid = 1'b0;
        bus.wstrb = 1'b0;
    endtask

    // Reference model: the LNA is settled once enough edges have passed since the
    // last settle start (power-up or mode change), with the length latched at that start.
    logic [2:0]  m_ctrl;
    logic [15:0] m_wake, m_mcyc;
    logic        m_pow, m_waking, m_on, m_rdy, m_ready, m_isrd, m_en;
    logic [1:0]  m_mode, m_want, m_code;
    logic [31:0] m_rdata, m_rv;
    int          m_t, m_start, m_len;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ctrl = 3'd0; m_wake = 16'd200; m_mcyc = 16'd20;
            m_pow = 1'b0; m_waking = 1'b0; m_on = 1'b0; m_rdy = 1'b0;
            m_ready = 1'b0; m_isrd = 1'b0; m_mode = 2'd0; m_rdata = 32'd0;
            m_t = 0; m_start = 0; m_len = 0;
        end else begin
            m_t++;
            m_en   = m_ctrl[0] | rx_req;
            m_want = rx_req ? rx_mode : m_ctrl[2:1];
            m_code = !m_pow ? 2'd0 : (m_on ? 2'd2 : (m_waking ? 2'd1 : 2'd3));
            case (bus.address)
                2'd0:    m_rv = {29'd0, m_ctrl};
                2'd1:    m_rv = {16'd0, m_wake};
                2'd2:    m_rv = {16'd0, m_mcyc};
                default: m_rv = {29'd0, m_on, m_code};
            endcase
            m_ready = bus.valid;
            m_isrd  = bus.valid && !bus.wstrb;
            m_rdata = m_isrd ? m_rv : 32'd0;
            if (!m_en) begin
                m_pow = 1'b0;
            end else if (!m_pow) begin
                m_pow = 1'b1; m_waking = 1'b1; m_mode = m_want;
                m_start = m_t; m_len = int'(m_wake) + 1;
            end else if (m_want != m_mode) begin
                if (m_on) m_waking = 1'b0;
                m_mode = m_want;
                m_start = m_t;
                m_len = m_waking ? int'(m_wake) + 1 : int'(m_mcyc) + 1;
            end
            m_on  = m_pow && ((m_t - m_start) >= m_len);
            m_rdy = m_on && rx_req && (m_mode == rx_mode);
            if (bus.valid && bus.wstrb) begin
                case (bus.address)
                    2'd0:    m_ctrl = bus.wdata[2:0];
                    2'd1:    m_wake = bus.wdata[15:0];
                    2'd2:    m_mcyc = bus.wdata[15:0];
                    default: ;
                endcase
            end
        end
    end

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        rdy;

        tbl[0]  = '{2'd0, 1'b0, 32'h0,        32'd0};
        tbl[1]  = '{2'd1, 1'b0, 32'h0,        32'd200};
        tbl[2]  = '{2'd2, 1'b0, 32'h0,        32'd20};
        tbl[3]  = '{2'd3, 1'b0, 32'h0,        32'd0};
        tbl[4]  = '{2'd1, 1'b1, 32'hABCD1234, 32'd0};
        tbl[5]  = '{2'd1, 1'b0, 32'h0,        32'h1234};
        tbl[6]  = '{2'd2, 1'b1, 32'h7,        32'd0};
        tbl[7]  = '{2'd2, 1'b0, 32'h0,        32'd7};
        tbl[8]  = '{2'd3, 1'b1, 32'hFFFFFFFF, 32'd0};
        tbl[9]  = '{2'd3, 1'b0, 32'h0,        32'd0};
        tbl[10] = '{2'd0, 1'b1, 32'hFFFFFFF8, 32'd0};
        tbl[11] = '{2'd0, 1'b0, 32'h0,        32'd0};

        bus.valid = 1'b0; bus.address = 2'd0; bus.wdata = 32'd0; bus.wstrb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        chk("rst_pd", 32'(pd), 32'd1);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_rx_rdy", 32'(rx_rdy), 32'd0);

        for (int i = 0; i < 12; i++) begin
            cpu_access(tbl[i].addr, tbl[i].wr, tbl[i].wdata, rd, rdy);
            chk("tbl_ready", 32'(rdy), 32'd1);
            if (!tbl[i].wr) chk("tbl_rdata", rd, tbl[i].exp);
        end

        // Wake with WAKE_CYC=5 under software control
        cpu_access(2'd1, 1'b1, 32'd5, rd, rdy);
        cpu_access(2'd0, 1'b1, 32'h5, rd, rdy);
        @(posedge clk); #1;
        chk("wake_pd", 32'(pd), 32'd0);
        chk("wake_mode", 32'(mode), 32'd2);
        repeat (5) @(posedge clk);
        cpu_access(2'd3, 1'b0, 32'd0, rd, rdy);
        chk("wake_last_status", rd, 32'd1);
        cpu_access(2'd3, 1'b0, 32'd0, rd, rdy);
        chk("wake_on_status", rd, 32'd6);

        // MAC takes over with a different mode: MODE_CYC=3 gives 4 MCHG cycles
        cpu_access(2'd2, 1'b1, 32'd3, rd, rdy);
        @(negedge clk); rx_req = 1'b1; rx_mode = 2'd1;
        @(posedge clk); #1;
        chk("mchg_mode", 32'(mode), 32'd1);
        chk("mchg_rdy0", 32'(rx_rdy), 32'd0);
        repeat (3) @(posedge clk); #1;
        chk("mchg_rdy_last", 32'(rx_rdy), 32'd0);
        @(posedge clk); #1;
        chk("mchg_rdy1", 32'(rx_rdy), 32'd1);
        chk("mchg_mode_on", 32'(mode), 32'd1);
        cpu_access(2'd3, 1'b0, 32'd0, rd, rdy);
        chk("mchg_status_on", rd, 32'd6);

        // Disable mid-wake
        @(negedge clk); rx_req = 1'b0;
        cpu_access(2'd0, 1'b1, 32'd0, rd, rdy);
        @(posedge clk); #1;
        chk("off_pd", 32'(pd), 32'd1);
        cpu_access(2'd1, 1'b1, 32'd10, rd, rdy);
        cpu_access(2'd0, 1'b1, 32'h5, rd, rdy);
        repeat (7) @(posedge clk);
        cpu_access(2'd0, 1'b1, 32'h0, rd, rdy);
        chk("abort_pd_before", 32'(pd), 32'd0);
        @(posedge clk); #1;
        chk("abort_pd", 32'(pd), 32'd1);
        chk("abort_rx_rdy", 32'(rx_rdy), 32'd0);
        cpu_access(2'd3, 1'b0, 32'd0, rd, rdy);
        chk("abort_status", rd, 32'd0);

        // WAKE_CYC=0 and MAC-only enable
        cpu_access(2'd1, 1'b1, 32'd0, rd, rdy);
        @(negedge clk); rx_req = 1'b1; rx_mode = 2'd3;
        @(posedge clk); #1;
        chk("w0_pd", 32'(pd), 32'd0);
        chk("w0_mode", 32'(mode), 32'd3);
        chk("w0_rdy0", 32'(rx_rdy), 32'd0);
        @(posedge clk); #1;
        chk("w0_rdy1", 32'(rx_rdy), 32'd1);
        @(negedge clk); rx_req = 1'b0;
        @(posedge clk); #1;
        chk("w0_off_pd", 32'(pd), 32'd1);
        chk("w0_off_rdy", 32'(rx_rdy), 32'd0);
        chk("w0_off_mode_hold", 32'(mode), 32'd3);

        // Asynchronous reset during MCHG
        @(negedge clk); rx_req = 1'b1; rx_mode = 2'd1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rx_mode = 2'd2;
        bus.valid = 1'b1; bus.address = 2'd0; bus.wstrb = 1'b0;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        chk("arst_pre_ready", 32'(bus.ready), 32'd1);
        chk("arst_pre_mode", 32'(mode), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pd", 32'(pd), 32'd1);
        chk("arst_mode", 32'(mode), 32'd0);
        chk("arst_ready", 32'(bus.ready), 32'd0);
        chk("arst_rx_rdy", 32'(rx_rdy), 32'd0);
        @(negedge clk); rst_n = 1'b1; rx_req = 1'b0;
        cpu_access(2'd1, 1'b0, 32'd0, rd, rdy);
        chk("arst_wake_reg", rd, 32'd200);
        cpu_access(2'd2, 1'b0, 32'd0, rd, rdy);
        chk("arst_mode_reg", rd, 32'd20);

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            chk("rnd_pd", 32'(pd), 32'(!m_pow));
            chk("rnd_mode", 32'(mode), 32'(m_mode));
            chk("rnd_rx_rdy", 32'(rx_rdy), 32'(m_rdy));
            chk("rnd_ready", 32'(bus.ready), 32'(m_ready));
            if (m_isrd) chk("rnd_rdata", bus.rdata, m_rdata);
            if ($urandom_range(0, 9) == 0) rx_req = ~rx_req;
            if ($urandom_range(0, 6) == 0) rx_mode = 2'($urandom_range(0, 3));
            bus.valid   = ($urandom_range(0, 3) == 0);
            bus.address = 2'($urandom_range(0, 3));
            bus.wstrb   = 1'($urandom_range(0, 1));
            bus.wdata   = (bus.address == 2'd0) ? $urandom : 32'($urandom_range(0, 6));
        end
        @(negedge clk);
        bus.valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
